// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle control unit: ULA operation codes,
// FSM state encodings, instruction opcode/funct fields and datapath mux selects.
// Optional feature macro: EXCEPTION_EN adds the EXCEPT state.
package ctrl_pkg;

    // ULA operation codes shared with the ULA datapath
    localparam logic [3:0] ULA_ADD  = 4'd0;
    localparam logic [3:0] ULA_SUB  = 4'd1;
    localparam logic [3:0] ULA_AND  = 4'd2;
    localparam logic [3:0] ULA_OR   = 4'd3;
    localparam logic [3:0] ULA_XOR  = 4'd4;
    localparam logic [3:0] ULA_NOR  = 4'd5;
    localparam logic [3:0] ULA_SLT  = 4'd6;
    localparam logic [3:0] ULA_SLTU = 4'd7;
    localparam logic [3:0] ULA_SLL  = 4'd8;
    localparam logic [3:0] ULA_SRL  = 4'd9;
    localparam logic [3:0] ULA_SRA  = 4'd10;
    localparam logic [3:0] ULA_SLLV = 4'd11;
    localparam logic [3:0] ULA_SRLV = 4'd12;
    localparam logic [3:0] ULA_SRAV = 4'd13;
    localparam logic [3:0] ULA_JR   = 4'd14;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_R_EXEC    = 4'd2,
        S_R_WB      = 4'd3,
        S_JR        = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_READ  = 4'd6,
        S_MEM_WB    = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_BRANCH    = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_JUMP      = 4'd12,
        S_JAL       = 4'd13
`ifdef EXCEPTION_EN
        , S_EXCEPT  = 4'd14
`endif
    } state_e;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // Datapath mux selects
    localparam logic [1:0] SRCA_PC      = 2'd0;
    localparam logic [1:0] SRCA_A       = 2'd1;
    localparam logic [1:0] SRCA_SHAMT   = 2'd2;
    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_BRANCH  = 2'd3;
    localparam logic [1:0] PCSRC_ULA    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_EXC    = 2'd3;
    localparam logic [1:0] DST_RT       = 2'd0;
    localparam logic [1:0] DST_RD       = 2'd1;
    localparam logic [1:0] DST_RA       = 2'd2;
    localparam logic [1:0] M2R_ALUOUT   = 2'd0;
    localparam logic [1:0] M2R_MDR      = 2'd1;
    localparam logic [1:0] M2R_PC       = 2'd2;

endpackage

// File: rtl/ula_ctrl.sv
// R-type funct decoder: maps funct to ULA operation and operand-A source,
// and flags funct codes the core does not implement.
module ula_ctrl
    import ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] ula_op_o,
    output logic [1:0] src_a_o,
    output logic       valid_o
);

    // Funct lookup; unknown codes leave everything at zero and clear valid
    always_comb begin
        ula_op_o = ULA_ADD;
        src_a_o  = SRCA_PC;
        valid_o  = 1'b1;
        case (funct_i)
            F_ADD, F_ADDU: begin ula_op_o = ULA_ADD;  src_a_o = SRCA_A;     end
            F_SUB, F_SUBU: begin ula_op_o = ULA_SUB;  src_a_o = SRCA_A;     end
            F_AND:         begin ula_op_o = ULA_AND;  src_a_o = SRCA_A;     end
            F_OR:          begin ula_op_o = ULA_OR;   src_a_o = SRCA_A;     end
            F_XOR:         begin ula_op_o = ULA_XOR;  src_a_o = SRCA_A;     end
            F_NOR:         begin ula_op_o = ULA_NOR;  src_a_o = SRCA_A;     end
            F_SLT:         begin ula_op_o = ULA_SLT;  src_a_o = SRCA_A;     end
            F_SLTU:        begin ula_op_o = ULA_SLTU; src_a_o = SRCA_A;     end
            F_SLL:         begin ula_op_o = ULA_SLL;  src_a_o = SRCA_SHAMT; end
            F_SRL:         begin ula_op_o = ULA_SRL;  src_a_o = SRCA_SHAMT; end
            F_SRA:         begin ula_op_o = ULA_SRA;  src_a_o = SRCA_SHAMT; end
            F_SLLV:        begin ula_op_o = ULA_SLLV; src_a_o = SRCA_A;     end
            F_SRLV:        begin ula_op_o = ULA_SRLV; src_a_o = SRCA_A;     end
            F_SRAV:        begin ula_op_o = ULA_SRAV; src_a_o = SRCA_A;     end
            default:       valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Multicycle Moore control FSM for the MIPS-style core. Opcode/funct come
// from the held IR; zero_flag and mem_ready only gate pc_we/ir_we and
// transitions. Optional feature macro: EXCEPTION_EN routes unsupported
// instructions through EXCEPT (EPC write, jump to exception vector);
// without it they retire as NOPs and epc_we stays 0.
module ctrl_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic [3:0] ula_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       ir_we,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [3:0] state,
    output logic       epc_we
);

`ifdef EXCEPTION_EN
    localparam state_e S_ILLEGAL = S_EXCEPT;
`else
    localparam state_e S_ILLEGAL = S_FETCH;
`endif

    state_e     state_q, state_d;
    logic [3:0] r_ula_op;
    logic [1:0] r_src_a;
    logic       r_valid;

    ula_ctrl u_ula_ctrl (
        .funct_i  (funct),
        .ula_op_o (r_ula_op),
        .src_a_o  (r_src_a),
        .valid_o  (r_valid)
    );

    assign state = state_q;

    // State register; reset abandons any access in flight and restarts at FETCH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                      state_d = (funct == F_JR) ? S_JR : S_R_EXEC;
                    OP_LW, OP_SW:                  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                state_d = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
                    OP_J:                          state_d = S_JUMP;
                    OP_JAL:                        state_d = S_JAL;
                    default:                       state_d = S_ILLEGAL;
                endcase
            end
            S_R_EXEC:    state_d = r_valid ? S_R_WB : S_ILLEGAL;
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_I_EXEC:    state_d = S_I_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    // Output decode from registered state; write strobes and mem_rd forced low in reset
    always_comb begin
        ula_op     = ULA_ADD;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_B;
        ext_zero   = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PCSRC_ULA;
        ir_we      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_ALUOUT;
        epc_we     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_rd    = 1'b1;
                ir_we     = mem_ready;
                alu_src_b = SRCB_FOUR;
                pc_we     = mem_ready;
            end
            S_DECODE:    alu_src_b = SRCB_BRANCH;
            S_R_EXEC: begin
                ula_op    = r_ula_op;
                alu_src_a = r_src_a;
            end
            S_R_WB: begin
                reg_dst = DST_RD;
                reg_we  = 1'b1;
            end
            S_JR: begin
                ula_op    = ULA_JR;
                alu_src_a = SRCA_A;
                pc_we     = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = M2R_MDR;
                reg_we     = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_A;
                ula_op    = ULA_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_we     = (opcode == OP_BEQ) ? zero_flag : ~zero_flag;
            end
            S_I_EXEC: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_SLTI: ula_op = ULA_SLT;
                    OP_ANDI: begin ula_op = ULA_AND; ext_zero = 1'b1; end
                    OP_ORI:  begin ula_op = ULA_OR;  ext_zero = 1'b1; end
                    default: ula_op = ULA_ADD;
                endcase
            end
            S_I_WB:      reg_we = 1'b1;
            S_JUMP: begin
                pc_src = PCSRC_JUMP;
                pc_we  = 1'b1;
            end
            S_JAL: begin
                pc_src     = PCSRC_JUMP;
                pc_we      = 1'b1;
                reg_dst    = DST_RA;
                mem_to_reg = M2R_PC;
                reg_we     = 1'b1;
            end
`ifdef EXCEPTION_EN
            S_EXCEPT: begin
                epc_we = 1'b1;
                pc_src = PCSRC_EXC;
                pc_we  = 1'b1;
            end
`endif
            default: ;
        endcase
        if (!reset_n) begin
            pc_we  = 1'b0;
            ir_we  = 1'b0;
            reg_we = 1'b0;
            mem_wr = 1'b0;
            mem_rd = 1'b0;
            epc_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit: table of instructions with expected per-state output
// words, queued as (mem_ready, expected) pairs and compared cycle by cycle,
// plus hand-built stall and reset-abort sequences.
module tb_ctrl_unit;
    import ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] state;
        logic [3:0] ula_op;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       ext_zero;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] m2r;
        logic       epc_we;
    } out_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       zf;
        logic [1:0] n;
        out_t       e0;
        out_t       e1;
        out_t       e2;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n, zero_flag, mem_ready;
    logic [5:0] opcode, funct;
    logic [3:0] ula_op, state;
    logic [1:0] alu_src_a, alu_src_b, pc_src, reg_dst, mem_to_reg;
    logic       ext_zero, pc_we, ir_we, mem_rd, mem_wr, iord, reg_we, epc_we;
    out_t       act;

    int   checks = 0;
    int   errors = 0;
    out_t expq[$];
    logic mrq[$];
    vec_t vecs[$];
    out_t FET, FET0, DEC, RWB, IWB, MADDR, MREAD, MWB, MWRITE, Z;

    ctrl_unit dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .zero_flag(zero_flag), .mem_ready(mem_ready), .ula_op(ula_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .iord(iord), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .state(state), .epc_we(epc_we)
    );

    assign act = {state, ula_op, alu_src_a, alu_src_b, ext_zero, pc_we, pc_src,
                  ir_we, mem_rd, mem_wr, iord, reg_we, reg_dst, mem_to_reg, epc_we};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic out_t mk(input logic [3:0] st, input logic [3:0] ula,
                                input int sa, sb, ez, pw, ps, irw, mrd, mwr, io,
                                input int rw, rd, m2r, ep);
        mk = {st, ula, sa[1:0], sb[1:0], ez[0], pw[0], ps[1:0], irw[0], mrd[0],
              mwr[0], io[0], rw[0], rd[1:0], m2r[1:0], ep[0]};
    endfunction

    function automatic out_t rex(input logic [3:0] ula, input int sa);
        rex = mk(S_R_EXEC, ula, sa, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic out_t iex(input logic [3:0] ula, input int ez);
        iex = mk(S_I_EXEC, ula, 1, 2, ez, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic out_t br(input int pw);
        br = mk(S_BRANCH, ULA_SUB, 1, 0, 0, pw, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t mkv(input int op, fn, zf, n, input out_t e0, e1, e2);
        mkv = {op[5:0], fn[5:0], zf[0], n[1:0], e0, e1, e2};
    endfunction

    task automatic check_out(input string nm, input out_t e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got state=%0d word=%07h, expected state=%0d word=%07h",
                     nm, act.state, act, e.state, e);
        end
    endtask

    task automatic check_v(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic push(input out_t e, input logic mr);
        expq.push_back(e);
        mrq.push_back(mr);
    endtask

    // Load IR fields just after the edge that enters FETCH
    task automatic start_instr(input logic [5:0] op, input logic [5:0] fn, input logic zf);
        @(posedge clk);
        #1;
        opcode    = op;
        funct     = fn;
        zero_flag = zf;
    endtask

    task automatic run_queue(input string tag);
        out_t e;
        int   cyc;
        cyc = 0;
        while (expq.size() > 0) begin
            @(negedge clk);
            mem_ready = mrq.pop_front();
            #1;
            e = expq.pop_front();
            check_out($sformatf("%s.c%0d", tag, cyc), e);
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        start_instr(v.op, v.fn, v.zf);
        push(FET, 1'b1);
        push(DEC, 1'b1);
        if (v.n >= 2'd1) push(v.e0, 1'b1);
        if (v.n >= 2'd2) push(v.e1, 1'b1);
        if (v.n >= 2'd3) push(v.e2, 1'b1);
        run_queue(tag);
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h00;
        zero_flag = 1'b0;
        mem_ready = 1'b1;

        Z      = '0;
        FET    = mk(S_FETCH, ULA_ADD, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        FET0   = mk(S_FETCH, ULA_ADD, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        DEC    = mk(S_DECODE, ULA_ADD, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        RWB    = mk(S_R_WB, ULA_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        IWB    = mk(S_I_WB, ULA_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        MADDR  = mk(S_MEM_ADDR, ULA_ADD, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        MREAD  = mk(S_MEM_READ, ULA_ADD, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        MWB    = mk(S_MEM_WB, ULA_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        MWRITE = mk(S_MEM_WRITE, ULA_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        vecs.push_back(mkv(8'h00, 8'h20, 0, 2, rex(ULA_ADD, 1), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h21, 0, 2, rex(ULA_ADD, 1), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h22, 0, 2, rex(ULA_SUB, 1), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h23, 0, 2, rex(ULA_SUB, 1), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h24, 0, 2, rex(ULA_AND, 1), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h25, 0, 2, rex(ULA_OR, 1), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h26, 0, 2, rex(ULA_XOR, 1), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h27, 0, 2, rex(ULA_NOR, 1), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h2A, 0, 2, rex(ULA_SLT, 1), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h2B, 0, 2, rex(ULA_SLTU, 1), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h00, 0, 2, rex(ULA_SLL, 2), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h02, 0, 2, rex(ULA_SRL, 2), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h03, 0, 2, rex(ULA_SRA, 2), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h04, 0, 2, rex(ULA_SLLV, 1), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h06, 0, 2, rex(ULA_SRLV, 1), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h07, 0, 2, rex(ULA_SRAV, 1), RWB, Z));
        vecs.push_back(mkv(8'h00, 8'h08, 0, 1,
                           mk(S_JR, ULA_JR, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), Z, Z));
        vecs.push_back(mkv(8'h23, 8'h00, 0, 3, MADDR, MREAD, MWB));
        vecs.push_back(mkv(8'h2B, 8'h00, 0, 2, MADDR, MWRITE, Z));
        vecs.push_back(mkv(8'h04, 8'h00, 1, 1, br(1), Z, Z));
        vecs.push_back(mkv(8'h04, 8'h00, 0, 1, br(0), Z, Z));
        vecs.push_back(mkv(8'h05, 8'h00, 1, 1, br(0), Z, Z));
        vecs.push_back(mkv(8'h05, 8'h00, 0, 1, br(1), Z, Z));
        vecs.push_back(mkv(8'h08, 8'h00, 0, 2, iex(ULA_ADD, 0), IWB, Z));
        vecs.push_back(mkv(8'h0A, 8'h00, 0, 2, iex(ULA_SLT, 0), IWB, Z));
        vecs.push_back(mkv(8'h0C, 8'h00, 0, 2, iex(ULA_AND, 1), IWB, Z));
        vecs.push_back(mkv(8'h0D, 8'h00, 0, 2, iex(ULA_OR, 1), IWB, Z));
        vecs.push_back(mkv(8'h02, 8'h00, 0, 1,
                           mk(S_JUMP, ULA_ADD, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0), Z, Z));
        vecs.push_back(mkv(8'h03, 8'h00, 0, 1,
                           mk(S_JAL, ULA_ADD, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 2, 2, 0), Z, Z));
`ifdef EXCEPTION_EN
        vecs.push_back(mkv(8'h3F, 8'h00, 0, 1,
                           mk(S_EXCEPT, ULA_ADD, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1), Z, Z));
        vecs.push_back(mkv(8'h00, 8'h01, 0, 2, rex(ULA_ADD, 0),
                           mk(S_EXCEPT, ULA_ADD, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1), Z));
`else
        vecs.push_back(mkv(8'h3F, 8'h00, 0, 0, Z, Z, Z));
        vecs.push_back(mkv(8'h00, 8'h01, 0, 1, rex(ULA_ADD, 0), Z, Z));
`endif

        // Reset holds FETCH with every strobe low, even with mem_ready high
        repeat (3) @(posedge clk);
        #2;
        check_v("rst_state", 32'(state), 32'(S_FETCH));
        check_v("rst_strobes", {26'd0, pc_we, ir_we, reg_we, mem_wr, mem_rd, epc_we}, 32'd0);
        mem_ready = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        #1 check_out("post_rst_fetch", FET0);

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], $sformatf("v%0d_op%02h_fn%02h_z%0d", i, vecs[i].op, vecs[i].fn, vecs[i].zf));

        // LW with two wait states in MEM_READ: 7 cycles total
        start_instr(6'h23, 6'h00, 1'b0);
        push(FET, 1'b1);
        push(DEC, 1'b1);
        push(MADDR, 1'b1);
        push(MREAD, 1'b0);
        push(MREAD, 1'b0);
        push(MREAD, 1'b1);
        push(MWB, 1'b1);
        run_queue("lw_stall");

        // SW with a fetch wait state, then reset asserted mid MEM_WRITE
        start_instr(6'h2B, 6'h00, 1'b0);
        push(FET0, 1'b0);
        push(FET, 1'b1);
        push(DEC, 1'b1);
        push(MADDR, 1'b1);
        push(MWRITE, 1'b0);
        run_queue("sw_abort");
        #1 reset_n = 1'b0;
        #1;
        check_v("abort_state", 32'(state), 32'(S_FETCH));
        check_v("abort_mem_wr", 32'(mem_wr), 32'd0);
        check_v("abort_mem_rd", 32'(mem_rd), 32'd0);
        check_v("abort_iord", 32'(iord), 32'd0);
        mem_ready = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        #1 check_out("abort_refetch", FET0);
        run_vec(vecs[0], "after_abort_add");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: opcode  in  6  IR[31:26]; funct  in  6  IR[5:0].
REQ-004 SHALL have: zero_flag  in  1  ULA Zero_Flag; mem_ready  in  1  memory access complete this cycle.
REQ-005 SHALL have: ula_op  out  4  ULA operation, encoded with the shared ULA opcode constants.
REQ-006 SHALL have: alu_src_a  out  2  0=PC, 1=A reg, 2=shamt.
REQ-007 SHALL have: alu_src_b  out  2  0=B reg, 1=const 4, 2=extended imm, 3=sign-ext imm<<2; ext_zero  out  1  zero-extend imm.
REQ-008 SHALL have: pc_we  out  1; pc_src  out  2  0=ULA result, 1=ALUOut, 2=jump target, 3=exception vector 0x8000_0180.
REQ-009 SHALL have: ir_we, mem_rd, mem_wr, iord  out  1 each; iord 1 = address from ALUOut.
REQ-010 SHALL have: reg_we  out  1; reg_dst  out  2  0=rt, 1=rd, 2=$31; mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC.
REQ-011 SHALL have: state  out  4  current state for debug; epc_we  out  1  (EXCEPTION_EN only).

Function
REQ-012 SHALL be a Moore FSM; all outputs decode from registered state only (zero_flag and mem_ready only gate pc_we/transitions).
REQ-013 FETCH: mem_rd=1, iord=0, ir_we=mem_ready, alu_src_a=0, alu_src_b=1, ula_op=ADD, pc_src=0, pc_we=mem_ready; stays until mem_ready=1, then DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=3, ula_op=ADD (branch target into ALUOut); next state by opcode.
REQ-015 opcode 0x00 -> R_EXEC -> R_WB (reg_dst=1, mem_to_reg=0, reg_we=1) -> FETCH; funct 0x08 (JR) -> JR state (pc_src=0, ula_op=JR, alu_src_a=1, pc_we=1) -> FETCH.
REQ-016 R_EXEC funct map: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, 0x00 SLL, 0x02 SRL, 0x03 SRA (alu_src_a=2), 0x04 SLLV, 0x06 SRLV, 0x07 SRAV (alu_src_a=1); alu_src_b=0.
REQ-017 LW 0x23/SW 0x2B -> MEM_ADDR (alu_src_a=1, alu_src_b=2, ADD) -> MEM_READ (mem_rd=1, iord=1, hold until mem_ready) -> MEM_WB (reg_dst=0, mem_to_reg=1, reg_we=1); or MEM_WRITE (mem_wr=1, iord=1, hold until mem_ready) -> FETCH.
REQ-018 BEQ 0x04/BNE 0x05 -> BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1; pc_we=zero_flag (BEQ) or ~zero_flag (BNE); -> FETCH.
REQ-019 ADDI 0x08, SLTI 0x0A, ANDI 0x0C, ORI 0x0D -> I_EXEC (alu_src_a=1, alu_src_b=2; ANDI/ORI ext_zero=1) -> I_WB (reg_dst=0, mem_to_reg=0, reg_we=1) -> FETCH.
REQ-020 J 0x02 -> JUMP (pc_src=2, pc_we=1); JAL 0x03 -> JAL (same plus reg_dst=2, mem_to_reg=2, reg_we=1); both -> FETCH.
REQ-021 Latency with mem_ready=1: R/I-type 4, LW 5, SW 4, branch 3, J/JAL/JR 3 cycles; each mem_ready=0 cycle adds one.
REQ-022 Outputs not listed for a state SHALL be 0; at most one of mem_rd/mem_wr high in any cycle.
REQ-023 Unsupported opcode/funct without EXCEPTION_EN SHALL return DECODE/R_EXEC -> FETCH with no register/memory write (NOP).

Reset
REQ-024 reset_n low SHALL force state=FETCH immediately and hold all write enables (pc_we, ir_we, reg_we, mem_wr, epc_we) and mem_rd at 0.
REQ-025 Reset mid-access SHALL abandon it; first fetch begins in the first cycle after reset_n rises.

Configuration
REQ-026 EXCEPTION_EN defined: unsupported opcode/funct -> EXCEPT (epc_we=1, pc_src=3, pc_we=1) -> FETCH; undefined: epc_we tied 0, EXCEPT absent, REQ-023 applies.

Structure
REQ-027 State encodings and opcode/funct constants SHALL live in shared package ctrl_pkg; ULA op codes come from the shared ULA opcode header.
REQ-028 Funct-to-ula_op mapping SHALL be sub-module ula_ctrl (combinational), instantiated once.

Verification
REQ-029 ADD funct 0x20, mem_ready=1 -> FETCH,DECODE,R_EXEC(ula_op=ADD),R_WB(reg_we=1,reg_dst=1) then FETCH; 4 cycles.
REQ-030 LW with mem_ready low 2 cycles in MEM_READ -> MEM_READ held 3 cycles, mem_rd=1 iord=1 throughout; total 7 cycles.
REQ-031 BEQ zero_flag=1 -> pc_we=1 pc_src=1 in BRANCH; BNE zero_flag=1 -> pc_we=0.
REQ-032 JAL -> reg_dst=2, mem_to_reg=2, reg_we=1, pc_src=2, pc_we=1 in one cycle.
REQ-033 reset_n low during MEM_WRITE -> mem_wr drops same cycle, state=FETCH.
REQ-034 opcode 0x3F -> with EXCEPTION_EN epc_we=1, pc_src=3; without, no write enable asserted before next FETCH.
